fifo_rd_arbiter: RTL and testbench
==================================

FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of FIFO read data and output data.
REQ-002 RClk  input  1  read-domain clock; all state updates on its rising edge.
REQ-003 PresetFull  input  1  reset, asynchronous, active-high.
REQ-004 fifo_empty  input  1  empty flag of the shared async FIFO read port.
REQ-005 fifo_rd_en  output  1  read enable to the FIFO read port.
REQ-006 fifo_data  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read.
REQ-007 req  input  3  per-requester burst request, bit i = requester i.
REQ-008 req_len0, req_len1, req_len2  input  4 each  burst length per requester; 0 encodes 16 words.
REQ-009 gnt  output  3  one-hot grant to the owning requester.
REQ-010 out_valid  output  1  out_data/out_last/out_id hold a word.
REQ-011 out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high.
REQ-012 out_data  output  DATA_WIDTH  delivered FIFO word.
REQ-013 out_last  output  1  marks the final word of the current burst.
REQ-014 out_id  output  2  index of the granted requester for the word.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, XFER, DRAIN; busy = (state != IDLE).
REQ-017 In IDLE with req != 0: select a winner round-robin, searching from (last_winner+1) mod 3; at the next edge, latch the winner, load remaining = its req_len (0 -> 16), drive gnt one-hot, enter XFER.
REQ-018 Read accepted = fifo_rd_en & ~fifo_empty; fifo_rd_en is high only in XFER with remaining > 0 and credit available.
REQ-019 Output buffer: 2 entries, FIFO order; credit available when (occupancy + inflight - pop) < 2, where pop = out_valid & out_ready and inflight is a read accepted at the previous edge.
REQ-020 Each accepted read decrements remaining by 1; the read issued at remaining = 1 carries a last tag.
REQ-021 fifo_data is written into the buffer at the edge following its accepted read, with its last tag and out_id; out_valid asserts after that edge.
REQ-022 Throughput is one word per cycle with out_ready held high and fifo_empty held low.
REQ-023 XFER -> DRAIN at the edge where remaining reaches 0.
REQ-024 DRAIN -> IDLE at the edge where the buffer empties with no read in flight; at that edge gnt -> 0 and last_winner <- owner.
REQ-025 gnt stays constant from XFER entry to DRAIN exit; deasserting req mid-burst does not shorten the burst.
REQ-026 req_len changes after the grant edge are ignored.
REQ-027 fifo_empty high stalls reads without leaving XFER; there is no timeout.
REQ-028 out_data/out_last/out_id hold stable while out_valid & ~out_ready.
REQ-029 Simultaneous requests from all three rotate 0 -> 1 -> 2 -> 0; a lone requester wins every arbitration.
REQ-030 Pop and buffer write in the same cycle leave occupancy unchanged.

Reset
REQ-031 PresetFull high: state IDLE, gnt 0, fifo_rd_en 0, out_valid 0, out_last 0, out_id 0, out_data 0, busy 0, buffer and inflight cleared, last_winner 2 (requester 0 first).
REQ-032 PresetFull mid-burst discards buffered and in-flight words.
REQ-033 After PresetFull deasserts, the first arbitration occurs at the first edge with req != 0.

Verification
REQ-034 req=001, req_len0=3, FIFO holding A,B,C, out_ready=1 -> gnt=001 one edge later; A,B,C on consecutive cycles with out_id 0; out_last only on C; gnt 0 and busy 0 after drain.
REQ-035 req=111 held, all lengths 1, FIFO non-empty -> grant order 001, 010, 100, 001; each word has out_last=1 and the matching out_id.
REQ-036 req_len1=0, FIFO holding 20 words -> exactly 16 accepted reads; out_last on the 16th word; 4 words left in the FIFO.
REQ-037 Burst of 4 with out_ready low for 5 cycles after the first word -> at most 2 buffered plus 0 in flight; no word lost or duplicated; data order preserved.
REQ-038 fifo_empty high for 3 cycles mid-burst -> fifo_rd_en low throughout, gnt held, burst resumes and completes.
REQ-039 PresetFull pulsed during XFER -> all outputs at reset values immediately; next req=110 grants requester 1 first.

Source files
------------

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter for a shared FIFO read port: grants one of three
// requesters a burst of reads and delivers the words through a 2-entry skid buffer.
module fifo_rd_arbiter #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  RClk,
    input  logic                  PresetFull,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic [2:0]            req,
    input  logic [3:0]            req_len0,
    input  logic [3:0]            req_len1,
    input  logic [3:0]            req_len2,
    output logic [2:0]            gnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [1:0]            out_id,
    output logic                  busy
);

    localparam int unsigned REM_W = 5;

    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t                 state, state_nx;
    logic [1:0]             owner, last_winner, winner_c;
    logic [1:0]             p0_c, p1_c, p2_c;
    logic [3:0]             req_pad_c;
    logic [3:0]             sel_len_c;
    logic [REM_W-1:0]       len_c, remaining;
    logic [1:0]             occ, occ_nx_c;
    logic [2:0]             level_c;
    logic                   wr_ptr, rd_ptr;
    logic                   infl, infl_last;
    logic                   pop_c, credit_c;
    logic [DATA_WIDTH-1:0]  mem_data [2];
    logic                   mem_last [2];
    logic [1:0]             mem_id   [2];

    // Round-robin search starting after the previous winner
    always_comb begin
        req_pad_c = {1'b0, req};
        case (last_winner)
            2'd0:    begin p0_c = 2'd1; p1_c = 2'd2; p2_c = 2'd0; end
            2'd1:    begin p0_c = 2'd2; p1_c = 2'd0; p2_c = 2'd1; end
            default: begin p0_c = 2'd0; p1_c = 2'd1; p2_c = 2'd2; end
        endcase
        if (req_pad_c[p0_c])      winner_c = p0_c;
        else if (req_pad_c[p1_c]) winner_c = p1_c;
        else                      winner_c = p2_c;
        case (winner_c)
            2'd1:    sel_len_c = req_len1;
            2'd2:    sel_len_c = req_len2;
            default: sel_len_c = req_len0;
        endcase
        len_c = (sel_len_c == 4'd0) ? REM_W'(16) : {1'b0, sel_len_c};
    end

    // Credit counts buffered words plus the word still in flight from the FIFO
    assign pop_c      = out_valid & out_ready;
    assign level_c    = {1'b0, occ} + {2'b00, infl} - {2'b00, pop_c};
    assign credit_c   = (level_c < 3'd2);
    assign occ_nx_c   = occ + {1'b0, infl} - {1'b0, pop_c};
    assign fifo_rd_en = (state == XFER) && (remaining != '0) && credit_c && !fifo_empty;

    assign out_data = mem_data[rd_ptr];
    assign out_last = mem_last[rd_ptr];
    assign out_id   = mem_id[rd_ptr];

    always_ff @(posedge RClk or posedge PresetFull) begin
        if (PresetFull) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req != 3'b000) state_nx = XFER;
            XFER:    if (fifo_rd_en && remaining == REM_W'(1)) state_nx = DRAIN;
            DRAIN:   if (occ_nx_c == 2'd0 && !infl) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Burst bookkeeping and grant
    always_ff @(posedge RClk or posedge PresetFull) begin
        if (PresetFull) begin
            owner       <= 2'd0;
            last_winner <= 2'd2;
            remaining   <= '0;
            gnt         <= 3'b000;
            busy        <= 1'b0;
        end else begin
            busy <= (state_nx != IDLE);
            if (state == IDLE && state_nx == XFER) begin
                owner     <= winner_c;
                remaining <= len_c;
                gnt       <= 3'b001 << winner_c;
            end else if (fifo_rd_en) begin
                remaining <= remaining - REM_W'(1);
            end
            if (state == DRAIN && state_nx == IDLE) begin
                gnt         <= 3'b000;
                last_winner <= owner;
            end
        end
    end

    // Two-entry output buffer, written the cycle after each accepted read
    always_ff @(posedge RClk or posedge PresetFull) begin
        if (PresetFull) begin
            infl      <= 1'b0;
            infl_last <= 1'b0;
            occ       <= 2'd0;
            out_valid <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
                mem_id[i]   <= 2'd0;
            end
        end else begin
            infl      <= fifo_rd_en;
            infl_last <= fifo_rd_en && (remaining == REM_W'(1));
            occ       <= occ_nx_c;
            out_valid <= (occ_nx_c != 2'd0);
            if (infl) begin
                mem_data[wr_ptr] <= fifo_data;
                mem_last[wr_ptr] <= infl_last;
                mem_id[wr_ptr]   <= owner;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop_c) rd_ptr <= ~rd_ptr;
        end
    end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Scoreboard bench for fifo_rd_arbiter: a behavioural FIFO feeds the DUT and a
// negedge monitor checks delivered words and grants against queued expectations.
module tb_fifo_rd_arbiter;

    logic       RClk = 1'b0;
    logic       PresetFull;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd_en;
    logic [7:0] fifo_data = 8'h00;
    logic [2:0] req;
    logic [3:0] req_len0, req_len1, req_len2;
    logic [2:0] gnt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic [1:0] out_id;
    logic       busy;

    typedef struct {
        logic [7:0] d;
        logic       last;
        logic [1:0] id;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] exp_gnt_q[$];
    logic [7:0] fq[$];
    int         word_cyc[$];
    int         n_total = 0;
    int         n_pass  = 0;
    int         n_reads = 0;
    int         gnt_seen = 0;
    int         words_seen = 0;
    int         cyc = 0;
    logic       force_empty = 1'b0;
    logic [2:0] gnt_prev = 3'b000;
    logic       stall_prev = 1'b0;
    logic [7:0] prev_d;
    logic       prev_last;
    logic [1:0] prev_id;

    fifo_rd_arbiter #(.DATA_WIDTH(8)) dut (
        .RClk(RClk), .PresetFull(PresetFull), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .req(req),
        .req_len0(req_len0), .req_len1(req_len1), .req_len2(req_len2),
        .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .out_id(out_id), .busy(busy)
    );

    initial forever #5 RClk = ~RClk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural FIFO: data appears the cycle after an accepted read
    always @(posedge RClk) begin
        cyc++;
        if (!PresetFull && fifo_rd_en && !fifo_empty && fq.size() > 0) begin
            fifo_data <= fq.pop_front();
            n_reads++;
        end
    end

    always begin
        @(posedge RClk);
        #2;
        fifo_empty = force_empty || (fq.size() == 0);
    end

    // Monitor: words, grants, hold-stability, and stall behaviour
    always @(negedge RClk) begin
        if (!PresetFull) begin
            if (stall_prev) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_d));
                chk("hold_last_id", 32'({out_last, out_id}), 32'({prev_last, prev_id}));
            end
            stall_prev = out_valid && !out_ready;
            prev_d = out_data; prev_last = out_last; prev_id = out_id;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word_data", 32'(out_data), 32'(e.d));
                    chk("word_last", 32'(out_last), 32'(e.last));
                    chk("word_id", 32'(out_id), 32'(e.id));
                end
                words_seen++;
                word_cyc.push_back(cyc);
            end
            if (gnt != gnt_prev && gnt != 3'b000) begin
                if (exp_gnt_q.size() == 0) chk("unexpected_gnt", 32'(gnt), 32'd0);
                else chk("gnt_order", 32'(gnt), 32'(exp_gnt_q.pop_front()));
                gnt_seen++;
            end
            if (force_empty && fifo_empty) begin
                chk("empty_no_rd", 32'(fifo_rd_en), 32'd0);
                chk("empty_gnt_held", 32'(gnt), 32'b001);
            end
        end
        gnt_prev = gnt;
    end

    task automatic tick();
        @(posedge RClk);
        #1;
    endtask

    task automatic push_word(input logic [1:0] id, input logic [7:0] d, input logic last);
        exp_t e;
        fq.push_back(d);
        e.d = d; e.last = last; e.id = id;
        exp_q.push_back(e);
    endtask

    task automatic burst(input logic [1:0] id, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) push_word(id, base + 8'(i), (i == n - 1));
    endtask

    task automatic wait_gnt(input int n);
        int t = 0;
        while (gnt_seen < n && t < 100) begin tick(); t++; end
        if (gnt_seen < n) chk("gnt_timeout", 32'(gnt_seen), 32'(n));
    endtask

    task automatic wait_words(input int n);
        int t = 0;
        while (words_seen < n && t < 100) begin tick(); t++; end
        if (words_seen < n) chk("word_timeout", 32'(words_seen), 32'(n));
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || exp_q.size() != 0) && t < 300) begin tick(); t++; end
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_gnt", 32'(gnt), 32'd0);
        chk("idle_exp_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
        chk({tag, "_id"}, 32'(out_id), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        PresetFull = 1'b1;
        req = 3'b000; req_len0 = 4'd0; req_len1 = 4'd0; req_len2 = 4'd0;
        out_ready = 1'b1;
        tick(); tick();
        chk_reset_outputs("reset");
        PresetFull = 1'b0;
        tick();

        // Requester 0, three words A,B,C back-to-back
        burst(2'd0, 3, 8'hA1);
        exp_gnt_q.push_back(3'b001);
        word_cyc.delete();
        req = 3'b001; req_len0 = 4'd3;
        tick();
        chk("grant_one_edge", 32'(gnt), 32'b001);
        req = 3'b000;
        wait_idle();
        chk("abc_count", 32'(word_cyc.size()), 32'd3);
        if (word_cyc.size() == 3) chk("abc_back_to_back", 32'(word_cyc[2] - word_cyc[0]), 32'd2);

        // All three requesting, length 1: rotation continues after winner 0
        push_word(2'd1, 8'h10, 1'b1); push_word(2'd2, 8'h11, 1'b1);
        push_word(2'd0, 8'h12, 1'b1); push_word(2'd1, 8'h13, 1'b1);
        exp_gnt_q.push_back(3'b010); exp_gnt_q.push_back(3'b100);
        exp_gnt_q.push_back(3'b001); exp_gnt_q.push_back(3'b010);
        req_len0 = 4'd1; req_len1 = 4'd1; req_len2 = 4'd1;
        req = 3'b111;
        wait_gnt(5);
        req = 3'b000;
        wait_idle();

        // Length code 0 reads exactly 16 of 20 words
        burst(2'd1, 16, 8'h40);
        for (int i = 0; i < 4; i++) fq.push_back(8'hE0 + 8'(i));
        exp_gnt_q.push_back(3'b010);
        n_reads = 0;
        req_len1 = 4'd0; req = 3'b010;
        tick();
        req_len1 = 4'd5;
        req = 3'b000;
        wait_idle();
        chk("len16_reads", 32'(n_reads), 32'd16);
        chk("len16_fifo_left", 32'(fq.size()), 32'd4);
        fq.delete();
        tick(); tick();

        // Burst of 4 with the consumer stalled for 5 cycles after the first word
        burst(2'd2, 4, 8'h70);
        exp_gnt_q.push_back(3'b100);
        req_len2 = 4'd4; req = 3'b100;
        tick();
        req = 3'b000;
        wait_words(words_seen + 1);
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        wait_idle();

        // FIFO empty for 3 cycles mid-burst
        burst(2'd0, 6, 8'h90);
        exp_gnt_q.push_back(3'b001);
        req_len0 = 4'd6; req = 3'b001;
        tick();
        req = 3'b000;
        wait_words(words_seen + 2);
        force_empty = 1'b1;
        repeat (3) tick();
        force_empty = 1'b0;
        wait_idle();

        // Reset mid-burst, then requester 1 must win first
        burst(2'd1, 8, 8'hC0);
        exp_gnt_q.push_back(3'b010);
        req_len1 = 4'd8; req = 3'b010;
        tick();
        req = 3'b000;
        tick(); tick();
        PresetFull = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        exp_q.delete(); exp_gnt_q.delete(); fq.delete();
        tick();
        PresetFull = 1'b0;
        tick();
        burst(2'd1, 2, 8'hD0);
        exp_gnt_q.push_back(3'b010);
        req_len1 = 4'd2; req = 3'b110;
        tick();
        chk("post_reset_gnt", 32'(gnt), 32'b010);
        req = 3'b000;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
